// File: rtl/wb_stage_pkg.sv
// Shared encodings for the write-back stage: result-select codes, load funct3 values
// and the MEM/WB register layout.
package wb_stage_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned CNT_W_DEF = 64;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_LOAD = 2'd1,
        WB_SEL_PC4  = 2'd2,
        WB_SEL_IMM  = 2'd3
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd;
        wb_sel_e     sel;
        logic [2:0]  funct3;
        logic [31:0] alu_result;
        logic [31:0] load_data;
        logic [31:0] pc_plus4;
        logic [31:0] imm;
    } wb_fields_t;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load-data alignment: extracts the addressed byte/halfword from a memory word and
// sign- or zero-extends it. Unknown funct3 values pass the raw word through.
module load_align
    import wb_stage_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_word,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
    end

    // Halfword loads ignore offset bit 0; a misaligned address is an upstream fault.
    assign w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    always_comb begin
        o_result = i_word;
        case (i_funct3)
            F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  o_result = {24'd0, w_byte};
            F3_LH:   o_result = {{16{w_half[15]}}, w_half};
            F3_LHU:  o_result = {16'd0, w_half};
            F3_LW:   o_result = i_word;
            default: o_result = i_word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I write-back stage: MEM/WB register, result select, register-bank write port,
// forwarding copy of that write, and the retired-instruction counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic [4:0]       mem_rd,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_funct3,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_load_data,
    input  logic [XLEN-1:0]  mem_pc_plus4,
    input  logic [XLEN-1:0]  mem_imm,
    output logic             wr_en,
    output logic [4:0]       w_addr,
    output logic [XLEN-1:0]  w_data,
    output logic             fwd_valid,
    output logic [4:0]       fwd_addr,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] instret
);

    wb_fields_t       r_wb;
    logic [CNT_W-1:0] r_instret;
    logic [31:0]      w_load_aligned;
    logic [31:0]      w_result;
    logic             w_wr_en;

    // Stall does not hold WB: the frozen MEM instruction is re-presented next cycle,
    // so WB takes a bubble and each instruction retires exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb <= '0;
        end else if (stall || flush) begin
            r_wb.valid <= 1'b0;
        end else begin
            r_wb.valid      <= mem_valid;
            r_wb.reg_write  <= mem_reg_write;
            r_wb.rd         <= mem_rd;
            r_wb.sel        <= wb_sel_e'(mem_wb_sel);
            r_wb.funct3     <= mem_funct3;
            r_wb.alu_result <= mem_alu_result;
            r_wb.load_data  <= mem_load_data;
            r_wb.pc_plus4   <= mem_pc_plus4;
            r_wb.imm        <= mem_imm;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instret <= '0;
        end else if (r_wb.valid) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    load_align u_load_align (
        .i_funct3 (r_wb.funct3),
        .i_offset (r_wb.alu_result[1:0]),
        .i_word   (r_wb.load_data),
        .o_result (w_load_aligned)
    );

    always_comb begin
        w_result = r_wb.alu_result;
        case (r_wb.sel)
            WB_SEL_ALU:  w_result = r_wb.alu_result;
            WB_SEL_LOAD: w_result = w_load_aligned;
            WB_SEL_PC4:  w_result = r_wb.pc_plus4;
            WB_SEL_IMM:  w_result = r_wb.imm;
            default:     w_result = r_wb.alu_result;
        endcase
    end

    // x0 is hardwired to zero, so its writes are dropped before the bank sees them.
    assign w_wr_en = r_wb.valid && r_wb.reg_write && (r_wb.rd != 5'd0);

    assign wr_en     = w_wr_en;
    assign w_addr    = r_wb.rd;
    assign w_data    = w_result;
    assign fwd_valid = w_wr_en;
    assign fwd_addr  = r_wb.rd;
    assign fwd_data  = w_result;
    assign instret   = r_instret;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized and directed bench for wb_stage against a behavioural model of the
// write-back rules (selection, load extraction, x0 suppression, bubbles, counting).
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, mem_valid, mem_reg_write;
    logic [4:0]  mem_rd;
    logic [1:0]  mem_wb_sel;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4, mem_imm;
    logic        wr_en, fwd_valid;
    logic [4:0]  w_addr, fwd_addr;
    logic [31:0] w_data, fwd_data;
    logic [63:0] instret;

    int n_vec = 0;
    int n_bad = 0;

    // model state
    bit          m_valid = 0;
    bit          m_rw    = 0;
    logic [4:0]  m_rd    = '0;
    logic [31:0] m_data  = '0;
    longint unsigned m_cnt = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
        .mem_wb_sel(mem_wb_sel), .mem_funct3(mem_funct3),
        .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
        .mem_pc_plus4(mem_pc_plus4), .mem_imm(mem_imm),
        .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .instret(instret)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        int unsigned b, h;
        b = (word >> (8 * (addr % 4))) & 32'hFF;
        h = (word >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_result();
        case (mem_wb_sel)
            2'd0:    return mem_alu_result;
            2'd1:    return ref_load(mem_funct3, mem_alu_result, mem_load_data);
            2'd2:    return mem_pc_plus4;
            default: return mem_imm;
        endcase
    endfunction

    // One clock: model tracks the edge, outputs are checked 1 ns after it.
    task automatic step();
        bit we;
        @(posedge clk);
        if (m_valid) m_cnt++;
        m_valid = mem_valid && !stall && !flush;
        if (m_valid) begin
            m_rw   = mem_reg_write;
            m_rd   = mem_rd;
            m_data = ref_result();
        end
        #1;
        we = m_valid && m_rw && (m_rd != 5'd0);
        chk("wr_en", {63'd0, wr_en}, {63'd0, we});
        chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, we});
        chk("instret", instret, m_cnt);
        if (we) begin
            chk("w_addr", {59'd0, w_addr}, {59'd0, m_rd});
            chk("w_data", {32'd0, w_data}, {32'd0, m_data});
            chk("fwd_addr", {59'd0, fwd_addr}, {59'd0, m_rd});
            chk("fwd_data", {32'd0, fwd_data}, {32'd0, m_data});
        end
        @(negedge clk);
    endtask

    task automatic put(input bit v, input bit rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] ld,
                       input logic [31:0] pc4, input logic [31:0] imm);
        mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_wb_sel = sel;
        mem_funct3 = f3; mem_alu_result = alu; mem_load_data = ld;
        mem_pc_plus4 = pc4; mem_imm = imm;
    endtask

    task automatic idle();
        stall = 0; flush = 0;
        put(0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #1;
        chk("rst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("rst_w_addr", {59'd0, w_addr}, 64'd0);
        chk("rst_w_data", {32'd0, w_data}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU write
        put(1, 1, 5'd5, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'd0, 32'd0, 32'd0);
        step();
        chk("alu_data", {32'd0, w_data}, 64'hDEAD_BEEF);
        idle();
        step();
        chk("alu_cnt", instret, 64'd1);

        // Loads from 0x8070F0A5
        put(1, 1, 5'd1, 2'd1, 3'd0, 32'h100, 32'h8070_F0A5, 0, 0); step();
        chk("lb0", {32'd0, w_data}, 64'hFFFF_FFA5);
        put(1, 1, 5'd2, 2'd1, 3'd4, 32'h101, 32'h8070_F0A5, 0, 0); step();
        chk("lbu1", {32'd0, w_data}, 64'h0000_00F0);
        put(1, 1, 5'd3, 2'd1, 3'd1, 32'h102, 32'h8070_F0A5, 0, 0); step();
        chk("lh2", {32'd0, w_data}, 64'hFFFF_8070);
        put(1, 1, 5'd4, 2'd1, 3'd5, 32'h100, 32'h8070_F0A5, 0, 0); step();
        chk("lhu0", {32'd0, w_data}, 64'h0000_F0A5);
        put(1, 1, 5'd6, 2'd1, 3'd2, 32'h103, 32'h8070_F0A5, 0, 0); step();
        chk("lw3", {32'd0, w_data}, 64'h8070_F0A5);

        // x0 and store: no write, still counted
        put(1, 1, 5'd0, 2'd0, 3'd0, 32'h55, 0, 0, 0); step();
        chk("x0_wr_en", {63'd0, wr_en}, 64'd0);
        put(1, 0, 5'd7, 2'd0, 3'd0, 32'h55, 0, 0, 0); step();
        chk("store_wr_en", {63'd0, wr_en}, 64'd0);

        // Link and LUI
        put(1, 1, 5'd8, 2'd2, 3'd0, 0, 0, 32'h104, 0); step();
        chk("link", {32'd0, w_data}, 64'h104);
        put(1, 1, 5'd9, 2'd3, 3'd0, 0, 0, 0, 32'h1234_5000); step();
        chk("lui", {32'd0, w_data}, 64'h1234_5000);
        idle(); step();
        chk("cnt_after_dir", instret, 64'd10);

        // Stall / flush / both, then release
        put(1, 1, 5'd10, 2'd0, 3'd0, 32'hA5A5, 0, 0, 0);
        stall = 1; step();
        chk("stall_wr_en", {63'd0, wr_en}, 64'd0);
        stall = 0; flush = 1; step();
        chk("flush_wr_en", {63'd0, wr_en}, 64'd0);
        stall = 1; step();
        chk("both_wr_en", {63'd0, wr_en}, 64'd0);
        stall = 0; flush = 0; step();
        idle(); step();
        chk("release_cnt", instret, 64'd11);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            put($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, $urandom);
            step();
        end

        // Reset mid-op: asynchronous clear, in-flight instruction discarded
        idle();
        put(1, 1, 5'd12, 2'd0, 3'd0, 32'hCAFE_F00D, 0, 0, 0);
        step();
        #1 rst = 1'b1;
        #1;
        chk("midrst_wr_en", {63'd0, wr_en}, 64'd0);
        chk("midrst_w_data", {32'd0, w_data}, 64'd0);
        chk("midrst_instret", instret, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        m_valid = 0; m_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            put(1, 1, 5'(i + 1), 2'd0, 3'd0, 32'(i * 16), 0, 0, 0);
            step();
        end
        idle(); step();
        chk("post_rst_cnt", instret, 64'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
